// File: rtl/spi_count_pkg.sv
// Shared opcodes, frame geometry, status bit positions and FSM states for the
// SPI count reader.
package spi_count_pkg;

    localparam logic [7:0] CMD_READ   = 8'hA1;
    localparam logic [7:0] CMD_STATUS = 8'hA2;
    localparam logic [3:0] CMD_SET_HI = 4'h5;

    localparam int CMD_BITS   = 8;
    localparam int FRAME_BITS = 40;
    localparam int CNT_W      = 6;
    localparam int STATUS_W   = 8;

    localparam int STAT_EMPTY    = 7;
    localparam int STAT_UNDERRUN = 6;
    localparam int STAT_LOST     = 5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        FETCH,
        RESP,
        WAIT_CS
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous SPI pin, with rise/fall strobes
// taken from the two oldest stages.
module spi_sync_edge #(
    parameter int STAGES = 3
) (
    input  logic clk_12mhz,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;

    // Clearing to zero means a chip select already low at reset release is
    // not mistaken for a fresh frame start.
    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], raw};
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = ~sync[STAGES-1] &  sync[STAGES-2];
    assign fall  =  sync[STAGES-1] & ~sync[STAGES-2];

endmodule

// File: rtl/spi_count_reader.sv
// SPI mode-0 slave that pops count-FIFO words for the host MCU and latches
// the pre-buffer command nibble.
module spi_count_reader
    import spi_count_pkg::*;
#(
    parameter int DATA_W      = 24,
    parameter int LEVEL_W     = 4,
    parameter int SYNC_STAGES = 3
) (
    input  logic               clk_12mhz,
    input  logic               reset,
    input  logic               spi_sck,
    input  logic               spi_cs_n,
    input  logic               spi_mosi,
    output logic               spi_miso,
    output logic               spi_miso_oe,
    input  logic [DATA_W-1:0]  fifo_dout,
    input  logic               fifo_empty,
    input  logic [LEVEL_W-1:0] fifo_level,
    output logic               fifo_rd_en,
    output logic [3:0]         spi_cmd,
    output logic               frame_done
);
    localparam int RESP_W = STATUS_W + DATA_W;

    state_t state, state_next;

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi;
    logic sck_level_unused, cs_level_unused;
    logic [1:0] mosi_edge_unused;

    logic [CNT_W-1:0]    bit_cnt;
    logic [CMD_BITS-1:0] cmd_shift;
    logic [CMD_BITS-1:0] opcode;
    logic [RESP_W-1:0]   resp;
    logic [STATUS_W-1:0] status;
    logic underrun, lost, popped, is_status;

    logic pop, load_status, capture, shift_resp, shift_cmd, set_cmd;
    logic set_underrun, set_lost, done, clear_sticky, cnt_clear, cnt_inc;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
        .clk_12mhz(clk_12mhz), .reset(reset), .raw(spi_sck),
        .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
        .clk_12mhz(clk_12mhz), .reset(reset), .raw(spi_cs_n),
        .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
        .clk_12mhz(clk_12mhz), .reset(reset), .raw(spi_mosi),
        .level(mosi), .rise(mosi_edge_unused[0]), .fall(mosi_edge_unused[1])
    );

    assign opcode = {cmd_shift[CMD_BITS-2:0], mosi};

    always_comb begin
        status                = '0;
        status[STAT_EMPTY]    = fifo_empty;
        status[STAT_UNDERRUN] = underrun;
        status[STAT_LOST]     = lost;
        status[LEVEL_W-1:0]   = fifo_level;
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        load_status  = 1'b0;
        capture      = 1'b0;
        shift_resp   = 1'b0;
        shift_cmd    = 1'b0;
        set_cmd      = 1'b0;
        set_underrun = 1'b0;
        set_lost     = 1'b0;
        done         = 1'b0;
        clear_sticky = 1'b0;
        cnt_clear    = 1'b0;
        cnt_inc      = 1'b0;
        if (state != IDLE && cs_rise) begin
            state_next = IDLE;
            set_lost   = popped && (state == FETCH || state == RESP);
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_next = CMD;
                        cnt_clear  = 1'b1;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        cnt_inc   = 1'b1;
                        shift_cmd = 1'b1;
                        if (bit_cnt == CNT_W'(CMD_BITS - 1)) begin
                            load_status = 1'b1;
                            if (opcode == CMD_READ && !fifo_empty) begin
                                pop        = 1'b1;
                                state_next = FETCH;
                            end else begin
                                state_next   = RESP;
                                set_underrun = (opcode == CMD_READ);
                                set_cmd      = (opcode[7:4] == CMD_SET_HI);
                            end
                        end
                    end
                end
                // First FETCH cycle carries the pop strobe; FIFO data lands on the second.
                FETCH: begin
                    cnt_inc = sck_rise;
                    if (!fifo_rd_en) begin
                        capture    = 1'b1;
                        state_next = RESP;
                    end
                end
                RESP: begin
                    shift_resp = sck_fall && (bit_cnt > CNT_W'(CMD_BITS));
                    if (sck_rise) begin
                        cnt_inc = 1'b1;
                        if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            state_next   = WAIT_CS;
                            done         = 1'b1;
                            clear_sticky = is_status;
                        end
                    end
                end
                WAIT_CS: begin
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            bit_cnt    <= '0;
            cmd_shift  <= '0;
            resp       <= '0;
            underrun   <= 1'b0;
            lost       <= 1'b0;
            popped     <= 1'b0;
            is_status  <= 1'b0;
            fifo_rd_en <= 1'b0;
            frame_done <= 1'b0;
            spi_cmd    <= '0;
        end else begin
            fifo_rd_en <= pop;
            frame_done <= done;
            if (cnt_clear) begin
                bit_cnt <= '0;
                popped  <= 1'b0;
            end else if (cnt_inc && bit_cnt != CNT_W'(FRAME_BITS)) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (pop) begin
                popped <= 1'b1;
            end
            if (shift_cmd) begin
                cmd_shift <= opcode;
            end
            if (load_status) begin
                resp      <= {status, {DATA_W{1'b0}}};
                is_status <= (opcode == CMD_STATUS);
            end else if (capture) begin
                resp[DATA_W-1:0] <= fifo_dout;
            end else if (shift_resp) begin
                resp <= {resp[RESP_W-2:0], 1'b0};
            end
            if (set_cmd) begin
                spi_cmd <= opcode[3:0];
            end
            // Clear first so a coincident set wins.
            if (clear_sticky) begin
                underrun <= 1'b0;
                lost     <= 1'b0;
            end
            if (set_underrun) begin
                underrun <= 1'b1;
            end
            if (set_lost) begin
                lost <= 1'b1;
            end
        end
    end

    assign spi_miso_oe = (state != IDLE);
    assign spi_miso    = (state == FETCH || state == RESP) ? resp[RESP_W-1] : 1'b0;

endmodule

// File: tb/tb_spi_count_reader.sv
// Self-checking bench for spi_count_reader: host-side SPI master, FIFO model,
// table-driven frames with a response scoreboard plus hand-written corner cases.
module tb_spi_count_reader;

    localparam int SYNC_STAGES = 3;
    localparam int CLK_HALF    = 42;
    localparam int SCK_HALF    = 504;

    logic        clk_12mhz = 1'b0;
    logic        reset     = 1'b1;
    logic        spi_sck   = 1'b0;
    logic        spi_cs_n  = 1'b1;
    logic        spi_mosi  = 1'b0;
    logic        spi_miso, spi_miso_oe, fifo_rd_en, frame_done;
    logic [3:0]  spi_cmd;
    logic [23:0] fifo_dout = '0;
    logic        fifo_empty;
    logic [3:0]  fifo_level;

    typedef struct {
        logic [23:0] load_word;
        logic        load_en;
        logic [7:0]  op;
        logic [7:0]  exp_status;
        logic [23:0] exp_data;
        int          exp_pops;
        logic [3:0]  exp_cmd;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    spi_count_reader dut (
        .clk_12mhz(clk_12mhz),
        .reset(reset),
        .spi_sck(spi_sck),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_level(fifo_level),
        .fifo_rd_en(fifo_rd_en),
        .spi_cmd(spi_cmd),
        .frame_done(frame_done)
    );

    always #(CLK_HALF) clk_12mhz = ~clk_12mhz;

    // FIFO model: the write side belongs to the stimulus process, the read
    // side to this block; data appears one cycle after the pop strobe.
    logic [23:0] fifo_mem [0:15];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_level = 4'(wr_ptr - rd_ptr);

    always @(posedge clk_12mhz) begin
        if (fifo_rd_en && wr_ptr != rd_ptr) begin
            fifo_dout <= fifo_mem[rd_ptr[3:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Event counters sampled on the falling clock edge, away from DUT updates.
    int   cyc = 0, pop_cnt = 0, done_cnt = 0, oe_cnt = 0, pop_empty_cnt = 0;
    int   rise_cnt = 0, rise8_cyc = 0, pop_cyc = 0;
    logic sck_prev = 1'b0;

    always @(negedge clk_12mhz) begin
        cyc++;
        if (fifo_rd_en) begin
            pop_cnt++;
            pop_cyc = cyc;
            if (fifo_empty) pop_empty_cnt++;
        end
        if (frame_done) done_cnt++;
        if (spi_miso_oe) oe_cnt++;
        if (spi_cs_n) begin
            rise_cnt = 0;
        end else if (spi_sck && !sck_prev) begin
            rise_cnt++;
            if (rise_cnt == 8) rise8_cyc = cyc;
        end
        sck_prev = spi_sck;
    end

    initial begin
        #(5_000_000);
        $display("[TB] FAIL watchdog: run still active at t=%0t, limit 5000000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic fifoPush(input logic [23:0] word);
        fifo_mem[wr_ptr[3:0]] = word;
        wr_ptr++;
    endtask

    // SPI mode-0 master: MOSI changes while SCK is low, MISO is sampled just
    // before each rising edge. Response bits are those sampled on rises 9..40.
    task automatic spiFrame(input logic [7:0] op, input int nbits, input logic raise_cs, output logic [31:0] rx);
        rx = '0;
        @(negedge clk_12mhz);
        #10;
        spi_cs_n = 1'b0;
        #(SCK_HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 8) ? op[7-i] : 1'b0;
            #(SCK_HALF);
            if (i >= 8 && i < 40) rx = {rx[30:0], spi_miso};
            spi_sck = 1'b1;
            #(SCK_HALF);
            spi_sck = 1'b0;
        end
        if (raise_cs) begin
            #(SCK_HALF);
            spi_cs_n = 1'b1;
            #(4*SCK_HALF);
        end
    endtask

    task automatic sckPulses(input int n);
        @(negedge clk_12mhz);
        #10;
        for (int i = 0; i < n; i++) begin
            #(SCK_HALF);
            spi_sck = 1'b1;
            #(SCK_HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int nbits, input string tag);
        logic [31:0] rx;
        logic [31:0] expected;
        int pops0, done0;
        if (v.load_en) fifoPush(v.load_word);
        pops0 = pop_cnt;
        done0 = done_cnt;
        exp_q.push_back({v.exp_status, v.exp_data});
        spiFrame(v.op, nbits, 1'b1, rx);
        expected = exp_q.pop_front();
        checkOutput({tag, "_resp"}, rx, expected);
        checkOutput({tag, "_pops"}, 32'(pop_cnt - pops0), 32'(v.exp_pops));
        checkOutput({tag, "_frame_done"}, 32'(done_cnt - done0), 32'd1);
        checkOutput({tag, "_spi_cmd"}, 32'(spi_cmd), 32'(v.exp_cmd));
        // Pin rise -> two flops to see the edge -> strobe registered on the third.
        if (v.exp_pops == 1)
            checkOutput({tag, "_pop_latency"}, 32'(pop_cyc - rise8_cyc), 32'(SYNC_STAGES - 1));
    endtask

    initial begin
        logic [31:0] rx;
        int pops0, done0, oe0, waited;
        vec_t v;

        vecs[0] = '{load_word:24'h123456, load_en:1'b1, op:8'hA1, exp_status:8'h01, exp_data:24'h123456, exp_pops:1, exp_cmd:4'h0};
        vecs[1] = '{load_word:24'h0,      load_en:1'b0, op:8'hA1, exp_status:8'h80, exp_data:24'h0,      exp_pops:0, exp_cmd:4'h0};
        vecs[2] = '{load_word:24'h0,      load_en:1'b0, op:8'hA2, exp_status:8'hC0, exp_data:24'h0,      exp_pops:0, exp_cmd:4'h0};
        vecs[3] = '{load_word:24'h0,      load_en:1'b0, op:8'hA2, exp_status:8'h80, exp_data:24'h0,      exp_pops:0, exp_cmd:4'h0};
        vecs[4] = '{load_word:24'h0,      load_en:1'b0, op:8'h53, exp_status:8'h80, exp_data:24'h0,      exp_pops:0, exp_cmd:4'h3};

        repeat (5) @(negedge clk_12mhz);
        checkOutput("reset_outputs", 32'({spi_miso, spi_miso_oe, fifo_rd_en, spi_cmd, frame_done}), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk_12mhz);

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], 40, $sformatf("vec%0d", i));

        // Abort a READ after 20 bits: one pop, lost becomes sticky.
        fifoPush(24'hABCDEF);
        fifoPush(24'h654321);
        pops0 = pop_cnt;
        done0 = done_cnt;
        spiFrame(8'hA1, 20, 1'b0, rx);
        @(negedge clk_12mhz);
        #10;
        spi_cs_n = 1'b1;
        waited = 0;
        while (spi_miso_oe && waited < SYNC_STAGES + 1) begin
            @(negedge clk_12mhz);
            waited++;
        end
        checkOutput("abort_oe_drop", 32'(spi_miso_oe), 32'd0);
        #(4*SCK_HALF);
        checkOutput("abort_pops", 32'(pop_cnt - pops0), 32'd1);
        checkOutput("abort_frame_done", 32'(done_cnt - done0), 32'd0);
        v = '{load_word:24'h0, load_en:1'b0, op:8'hA2, exp_status:8'h21, exp_data:24'h0, exp_pops:0, exp_cmd:4'h3};
        applyStimulus(v, 40, "after_abort_status");

        // Reset during the response with chip select held low.
        fifoPush(24'h0F0F0F);
        spiFrame(8'hA1, 20, 1'b0, rx);
        @(negedge clk_12mhz);
        reset = 1'b1;
        repeat (3) @(negedge clk_12mhz);
        checkOutput("reset_mid_outputs", 32'({spi_miso, spi_miso_oe, fifo_rd_en, spi_cmd, frame_done}), 32'd0);
        reset = 1'b0;
        pops0 = pop_cnt;
        done0 = done_cnt;
        oe0   = oe_cnt;
        sckPulses(20);
        checkOutput("reset_ignored_pops", 32'(pop_cnt - pops0), 32'd0);
        checkOutput("reset_ignored_done", 32'(done_cnt - done0), 32'd0);
        checkOutput("reset_ignored_oe", 32'(oe_cnt - oe0), 32'd0);
        #(SCK_HALF);
        spi_cs_n = 1'b1;
        #(4*SCK_HALF);
        v = '{load_word:24'h0, load_en:1'b0, op:8'hA1, exp_status:8'h01, exp_data:24'h0F0F0F, exp_pops:1, exp_cmd:4'h0};
        applyStimulus(v, 40, "after_reset_read");

        // 45 SCK pulses: bits beyond 40 must be ignored.
        v = '{load_word:24'hC0FFEE, load_en:1'b1, op:8'hA1, exp_status:8'h01, exp_data:24'hC0FFEE, exp_pops:1, exp_cmd:4'h0};
        applyStimulus(v, 45, "overclock_read");
        v = '{load_word:24'h0, load_en:1'b0, op:8'hA2, exp_status:8'h80, exp_data:24'h0, exp_pops:0, exp_cmd:4'h0};
        applyStimulus(v, 40, "final_status");

        checkOutput("pop_while_empty", 32'(pop_empty_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
